// File: rtl/bp_fpga_host_nbf_tx_arbiter_if.sv
// Bus bundle between NBF packet requesters / UART transmitter and the TX arbiter.
// master: requesters and UART side; slave: the arbiter.
interface bp_fpga_host_nbf_tx_arbiter_if #(
  parameter int unsigned num_req_p          = 3,
  parameter int unsigned nbf_opcode_width_p = 8,
  parameter int unsigned nbf_addr_width_p   = 40,
  parameter int unsigned nbf_data_width_p   = 64
);

  localparam int unsigned nbf_width_lp = nbf_opcode_width_p + nbf_addr_width_p
                                         + nbf_data_width_p;
  localparam int unsigned id_width_lp  = $clog2(num_req_p);

  logic [num_req_p*nbf_width_lp-1:0] nbf_i;
  logic [num_req_p-1:0]              nbf_v_i;
  logic [num_req_p-1:0]              nbf_yumi_o;
  logic [7:0]                        tx_byte_o;
  logic                              tx_v_o;
  logic                              tx_ready_and_i;
  logic                              busy_o;
  logic [id_width_lp-1:0]            grant_id_o;

  modport master (
    output nbf_i,
    output nbf_v_i,
    output tx_ready_and_i,
    input  nbf_yumi_o,
    input  tx_byte_o,
    input  tx_v_o,
    input  busy_o,
    input  grant_id_o
  );

  modport slave (
    input  nbf_i,
    input  nbf_v_i,
    input  tx_ready_and_i,
    output nbf_yumi_o,
    output tx_byte_o,
    output tx_v_o,
    output busy_o,
    output grant_id_o
  );

endinterface

// File: rtl/bp_fpga_host_nbf_tx_arbiter.sv
// Round-robin arbiter that grants whole NBF packets to one requester at a time and
// serializes the granted packet LSB byte first onto the host UART TX byte stream.
module bp_fpga_host_nbf_tx_arbiter #(
  parameter int unsigned num_req_p          = 3,
  parameter int unsigned nbf_opcode_width_p = 8,
  parameter int unsigned nbf_addr_width_p   = 40,
  parameter int unsigned nbf_data_width_p   = 64
) (
  input logic                          clk_i,
  input logic                          reset_i,
  bp_fpga_host_nbf_tx_arbiter_if.slave bus
);

  localparam int unsigned nbf_width_lp   = nbf_opcode_width_p + nbf_addr_width_p
                                           + nbf_data_width_p;
  localparam int unsigned nbf_bytes_lp   = nbf_width_lp / 8;
  localparam int unsigned id_width_lp    = $clog2(num_req_p);
  localparam int unsigned sum_width_lp   = id_width_lp + 1;
  localparam int unsigned count_width_lp = $clog2(nbf_bytes_lp);

  localparam logic [id_width_lp-1:0]    last_id_lp    = id_width_lp'(num_req_p - 1);
  localparam logic [count_width_lp-1:0] last_count_lp = count_width_lp'(nbf_bytes_lp - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                    state_q;
  logic [nbf_width_lp-1:0]   shift_q;
  logic [count_width_lp-1:0] count_q;
  logic [id_width_lp-1:0]    ptr_q;
  logic [id_width_lp-1:0]    grant_q;

  logic                      found;
  logic [id_width_lp-1:0]    gnt;
  logic [sum_width_lp-1:0]   sum;
  logic [id_width_lp-1:0]    idx;
  logic [nbf_width_lp-1:0]   sel_pkt;
  logic [num_req_p-1:0]      yumi;

  // Rotating priority search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    sum   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      sum = {1'b0, ptr_q} + sum_width_lp'(i);
      if (sum >= sum_width_lp'(num_req_p)) begin
        sum = sum - sum_width_lp'(num_req_p);
      end
      idx = sum[id_width_lp-1:0];
      if (!found && bus.nbf_v_i[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  // Packet mux for the winning requester.
  always_comb begin
    sel_pkt = '0;
    for (int unsigned k = 0; k < num_req_p; k++) begin
      if (gnt == id_width_lp'(k)) begin
        sel_pkt = bus.nbf_i[k*nbf_width_lp +: nbf_width_lp];
      end
    end
  end

  // Consume the packet in the grant cycle; suppressed while reset is asserted.
  always_comb begin
    yumi = '0;
    if ((state_q == StIdle) && found && !reset_i) begin
      yumi[gnt] = 1'b1;
    end
  end

  // Packet FSM: latch the granted packet, then shift one byte out per accepted handshake.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      shift_q <= '0;
      count_q <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (found) begin
            shift_q <= sel_pkt;
            grant_q <= gnt;
            ptr_q   <= (gnt == last_id_lp) ? '0 : gnt + id_width_lp'(1);
            count_q <= '0;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (bus.tx_ready_and_i) begin
            shift_q <= shift_q >> 8;
            if (count_q == last_count_lp) begin
              // Clear so the counter never reads as an out-of-range byte index.
              count_q <= '0;
              state_q <= StIdle;
            end else begin
              count_q <= count_q + count_width_lp'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.nbf_yumi_o = yumi;
  assign bus.tx_v_o     = (state_q == StSend);
  assign bus.tx_byte_o  = shift_q[7:0];
  assign bus.busy_o     = (state_q == StSend);
  assign bus.grant_id_o = grant_q;

  a_yumi_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
    $onehot0(yumi));

  a_yumi_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    (yumi & ~bus.nbf_v_i) == '0);

  a_count_range: assert property (@(posedge clk_i)
    {1'b0, count_q} < (count_width_lp + 1)'(nbf_bytes_lp));

  a_tx_hold: assert property (@(posedge clk_i) disable iff (reset_i)
    (bus.tx_v_o && !bus.tx_ready_and_i) |=> (bus.tx_v_o && $stable(bus.tx_byte_o)));

endmodule

// File: tb/tb_bp_fpga_host_nbf_tx_arbiter.sv
// Directed and random checks of the NBF TX arbiter: vector table for a single packet,
// hand sequences for arbitration order, stalls and reset, then a scoreboarded stress run.
module tb_bp_fpga_host_nbf_tx_arbiter;

  localparam int unsigned N = 3;
  localparam int unsigned W = 112;
  localparam int unsigned B = 14;

  typedef struct packed {
    logic [2:0] v;
    logic       rdy;
    logic [2:0] yumi;
    logic       txv;
    logic [7:0] b;
    logic       busy;
    logic [1:0] gid;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bp_fpga_host_nbf_tx_arbiter_if #(
    .num_req_p          (N),
    .nbf_opcode_width_p (8),
    .nbf_addr_width_p   (40),
    .nbf_data_width_p   (64)
  ) bus ();

  bp_fpga_host_nbf_tx_arbiter #(
    .num_req_p          (N),
    .nbf_opcode_width_p (8),
    .nbf_addr_width_p   (40),
    .nbf_data_width_p   (64)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [7:0]   t1b [B] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h41,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  vec_t         tbl [$];
  logic [W-1:0] p [N];
  logic         regen [N];
  logic [7:0]   exp_q [$];
  logic         prev_stall;
  logic [7:0]   prev_byte;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic [2:0] v, input logic rdy, input logic [2:0] yumi,
                               input logic txv, input logic [7:0] b, input logic busy,
                               input logic [1:0] gid);
    vec_t r;
    r.v = v; r.rdy = rdy; r.yumi = yumi; r.txv = txv; r.b = b; r.busy = busy; r.gid = gid;
    return r;
  endfunction

  function automatic logic [W-1:0] mk_pkt(input logic [7:0] op, input logic [39:0] addr,
                                          input logic [63:0] data);
    return {data, addr, op};
  endfunction

  function automatic logic [7:0] byte_of(input logic [W-1:0] pkt, input int j);
    logic [W-1:0] t;
    t = pkt >> (8 * j);
    return t[7:0];
  endfunction

  function automatic logic [W-1:0] rnd_pkt();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  task automatic set_pkt(input int k, input logic [W-1:0] pkt);
    bus.nbf_i[k*W +: W] = pkt;
  endtask

  // Check one cycle at the falling edge, then advance to just after the next rising edge.
  task automatic cyc(input string name, input logic [2:0] yumi, input logic txv,
                     input logic [7:0] b, input logic busy, input logic [1:0] gid);
    @(negedge clk);
    chk({name, ".yumi"}, 64'(bus.nbf_yumi_o), 64'(yumi));
    chk({name, ".txv"},  64'(bus.tx_v_o),     64'(txv));
    if (txv) chk({name, ".byte"}, 64'(bus.tx_byte_o), 64'(b));
    chk({name, ".busy"}, 64'(bus.busy_o),     64'(busy));
    chk({name, ".gid"},  64'(bus.grant_id_o), 64'(gid));
    @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input string name, input logic [W-1:0] pkt, input logic [1:0] g);
    for (int j = 0; j < B; j++) begin
      cyc($sformatf("%s_b%0d", name, j), 3'b000, 1'b1, byte_of(pkt, j), 1'b1, g);
    end
  endtask

  // Scoreboard step at the falling edge for the random run.
  task automatic observe();
    logic [2:0] y;
    y = bus.nbf_yumi_o;
    chk("s_yumi_legal", 64'($onehot0(y) && ((y & ~bus.nbf_v_i) == 3'b000)), 64'd1);
    if (prev_stall) begin
      chk("s_hold_v", 64'(bus.tx_v_o), 64'd1);
      chk("s_hold_b", 64'(bus.tx_byte_o), 64'(prev_byte));
    end
    for (int k = 0; k < N; k++) begin
      if (y[k]) begin
        for (int j = 0; j < B; j++) exp_q.push_back(byte_of(p[k], j));
        regen[k] = 1'b1;
      end
    end
    if (bus.tx_v_o && bus.tx_ready_and_i) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL s_extra_byte: got %0h expected no byte (t=%0t)", bus.tx_byte_o, $time);
      end else begin
        chk("s_byte", 64'(bus.tx_byte_o), 64'(exp_q.pop_front()));
      end
    end
    prev_stall = bus.tx_v_o && !bus.tx_ready_and_i;
    prev_byte  = bus.tx_byte_o;
  endtask

  initial begin
    reset              = 1'b1;
    bus.nbf_i          = '0;
    bus.nbf_v_i        = '0;
    bus.tx_ready_and_i = 1'b0;
    prev_stall         = 1'b0;
    prev_byte          = '0;
    repeat (3) @(posedge clk);
    #1;
    cyc("reset", 3'b000, 1'b0, 8'h00, 1'b0, 2'd0);
    reset = 1'b0;

    // Single packet from req0 with continuous ready.
    set_pkt(0, mk_pkt(8'h01, 40'h0010000000, 64'h41));
    tbl.push_back(mkv(3'b001, 1'b1, 3'b001, 1'b0, 8'h00, 1'b0, 2'd0));
    for (int j = 0; j < B; j++) tbl.push_back(mkv(3'b000, 1'b1, 3'b000, 1'b1, t1b[j], 1'b1, 2'd0));
    tbl.push_back(mkv(3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 2'd0));
    foreach (tbl[i]) begin
      bus.nbf_v_i        = tbl[i].v;
      bus.tx_ready_and_i = tbl[i].rdy;
      cyc($sformatf("t1_%0d", i), tbl[i].yumi, tbl[i].txv, tbl[i].b, tbl[i].busy, tbl[i].gid);
    end

    // All three requesters valid from reset: 0,1,2,0,1,2 with one bubble per packet.
    reset = 1'b1;
    for (int k = 0; k < N; k++) begin
      p[k] = mk_pkt(8'h10 + 8'(k), 40'h12_3456_7800 + 40'(k), 64'hA5A5_0000_0000_0000 + 64'(k));
      set_pkt(k, p[k]);
    end
    bus.nbf_v_i = 3'b111;
    cyc("t2_rst", 3'b000, 1'b0, 8'h00, 1'b0, 2'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc($sformatf("t2_g%0d", i), 3'(1 << (i % 3)), 1'b0, 8'h00, 1'b0,
          (i == 0) ? 2'd0 : 2'((i - 1) % 3));
      send_bytes($sformatf("t2_p%0d", i), p[i % 3], 2'(i % 3));
    end
    bus.nbf_v_i = 3'b000;
    cyc("t2_end", 3'b000, 1'b0, 8'h00, 1'b0, 2'd2);

    // Req1 with 20 stall cycles after byte 3.
    p[1] = mk_pkt(8'h03, 40'hFE_DCBA_9876, 64'h0123_4567_89AB_CDEF);
    set_pkt(1, p[1]);
    bus.nbf_v_i = 3'b010;
    cyc("t3_g", 3'b010, 1'b0, 8'h00, 1'b0, 2'd2);
    bus.nbf_v_i = 3'b000;
    for (int j = 0; j < 4; j++) cyc($sformatf("t3_b%0d", j), 3'b000, 1'b1, byte_of(p[1], j), 1'b1, 2'd1);
    bus.tx_ready_and_i = 1'b0;
    for (int s = 0; s < 20; s++) cyc($sformatf("t3_s%0d", s), 3'b000, 1'b1, byte_of(p[1], 4), 1'b1, 2'd1);
    bus.tx_ready_and_i = 1'b1;
    for (int j = 4; j < B; j++) cyc($sformatf("t3_b%0d", j), 3'b000, 1'b1, byte_of(p[1], j), 1'b1, 2'd1);
    cyc("t3_end", 3'b000, 1'b0, 8'h00, 1'b0, 2'd1);

    // Reset after byte 5 of a req1 packet, then req2 sent from byte 0.
    p[1] = mk_pkt(8'h04, 40'h11_2233_4455, 64'h6677_8899_AABB_CCDD);
    set_pkt(1, p[1]);
    bus.nbf_v_i = 3'b010;
    cyc("t4_g", 3'b010, 1'b0, 8'h00, 1'b0, 2'd1);
    bus.nbf_v_i = 3'b000;
    for (int j = 0; j < 6; j++) cyc($sformatf("t4_b%0d", j), 3'b000, 1'b1, byte_of(p[1], j), 1'b1, 2'd1);
    reset = 1'b1;
    p[2] = mk_pkt(8'h05, 40'h99_8877_6655, 64'hDEAD_BEEF_CAFE_F00D);
    set_pkt(2, p[2]);
    bus.nbf_v_i = 3'b100;
    cyc("t4_rst", 3'b000, 1'b1, byte_of(p[1], 6), 1'b1, 2'd1);
    reset = 1'b0;
    cyc("t4_post", 3'b100, 1'b0, 8'h00, 1'b0, 2'd0);
    bus.nbf_v_i = 3'b000;
    send_bytes("t4_p2", p[2], 2'd2);
    cyc("t4_end", 3'b000, 1'b0, 8'h00, 1'b0, 2'd2);

    // Pointer wrapped to 0: reqs 0 and 2 together -> 0 first, then 2.
    p[0] = mk_pkt(8'h06, 40'h00_0000_00FF, 64'h1111_2222_3333_4444);
    p[2] = mk_pkt(8'h07, 40'hAB_CDEF_0123, 64'h5555_6666_7777_8888);
    set_pkt(0, p[0]);
    set_pkt(2, p[2]);
    bus.nbf_v_i = 3'b101;
    cyc("t5_g0", 3'b001, 1'b0, 8'h00, 1'b0, 2'd2);
    bus.nbf_v_i = 3'b100;
    send_bytes("t5_p0", p[0], 2'd0);
    cyc("t5_g2", 3'b100, 1'b0, 8'h00, 1'b0, 2'd0);
    bus.nbf_v_i = 3'b000;
    send_bytes("t5_p2", p[2], 2'd2);
    cyc("t5_end", 3'b000, 1'b0, 8'h00, 1'b0, 2'd2);

    // Random valid/ready stress with a byte-order scoreboard.
    for (int k = 0; k < N; k++) regen[k] = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (regen[k]) begin
          p[k] = rnd_pkt();
          set_pkt(k, p[k]);
          regen[k] = 1'b0;
        end
      end
      bus.nbf_v_i        = {($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                            ($urandom_range(0, 3) == 0)};
      bus.tx_ready_and_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
    end
    bus.nbf_v_i        = 3'b000;
    bus.tx_ready_and_i = 1'b1;
    for (int c = 0; c < 40 && (exp_q.size() != 0 || bus.tx_v_o); c++) begin
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
    end
    chk("drain_q", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk("drain_txv", 64'(bus.tx_v_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
